// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// The instruction path is 32 bits wide and needs no backpressure of its own.
package fetch_pkg;

  localparam int          INSTR_BYTES     = 4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Groups the memory request/response, redirect and decode handshakes of the prefetch queue.
// The master modport is the queue; the slave modport is the memory plus decode side.
interface fetch_prefetch_queue_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_code, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_code, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with clear: a write is visible at the head one cycle later.
// The caller must never push when full or pop when empty; both are also ignored internally.
module fetch_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage has no reset; stale slots are never observable because the count gates reads.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetch stage: credit-limited in-order fetch into a DEPTH-entry queue; redirect flushes and restarts.
// Build option FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_prefetch_queue_if.master bus
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [31:0]   PC_STEP   = 32'(INSTR_BYTES);

  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;

  logic [CW:0]  credits_used;
  logic         req_valid;
  logic         req_fire;
  logic         rsp_keep;
  logic         fifo_empty;
  logic         bypass;
  logic         push;
  logic         pop;
  logic         out_valid;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  fetch_entry_t out_entry;

  // Every accepted request owns a queue slot until its word is popped or dropped.
  assign credits_used = {1'b0, count} + {1'b0, inflight};
  assign req_valid    = !reset && !bus.redirect_valid && (credits_used < DEPTH_LIM);
  assign req_fire     = req_valid && bus.imem_req_ready;
  assign rsp_keep     = bus.imem_rsp_valid && (drop == '0);
  assign fifo_empty   = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass    = rsp_keep && fifo_empty && bus.instr_ready && !bus.redirect_valid && !reset;
  assign out_valid = !fifo_empty || bypass;
  assign out_entry = bypass ? push_entry : head_entry;
`else
  assign bypass    = 1'b0;
  assign out_valid = !fifo_empty;
  assign out_entry = head_entry;
`endif

  assign push_entry = '{pc: rsp_pc, code: bus.imem_rsp_data};
  assign push       = rsp_keep && !bus.redirect_valid && !bypass;
  assign pop        = !fifo_empty && bus.instr_ready && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = out_valid;
  assign bus.instr_code     = out_valid ? out_entry.code : 32'h0;
  assign bus.instr_pc       = out_valid ? out_entry.pc   : 32'h0;

  fetch_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle's response belongs to the old stream.
      fetch_pc <= word_align(bus.redirect_pc);
      rsp_pc   <= word_align(bus.redirect_pc);
      inflight <= inflight - CW'(bus.imem_rsp_valid);
      drop     <= inflight - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue (DEPTH 4): cycle vector table plus stall and flush sequences.
module tb_fetch_prefetch_queue;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_prefetch_queue_if bus();

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        req_rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        redir;
    logic [31:0] redir_pc;
    logic        in_rdy;
    logic        e_req_v;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_code;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rst, rr, rv, input logic [31:0] rd,
                              input logic rdv, input logic [31:0] rdpc, input logic ir,
                              input logic erv, input logic [31:0] eaddr, input logic eiv,
                              input logic [31:0] ecode, epc);
    vec_t v;
    v.rst = rst; v.req_rdy = rr; v.rsp_v = rv; v.rsp_d = rd; v.redir = rdv;
    v.redir_pc = rdpc; v.in_rdy = ir; v.e_req_v = erv; v.e_addr = eaddr;
    v.e_iv = eiv; v.e_code = ecode; v.e_pc = epc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic apply(input logic rst, rr, rv, input logic [31:0] rd,
                       input logic rdv, input logic [31:0] rdpc, input logic ir);
    @(negedge clock);
    reset              = rst;
    bus.imem_req_ready = rr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rdpc;
    bus.instr_ready    = ir;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic erv, input logic [31:0] eaddr,
                            input logic eiv, input logic [31:0] ecode, epc);
    check({tag, " req_valid"},   32'(bus.imem_req_valid), 32'(erv));
    check({tag, " req_addr"},    bus.imem_req_addr, eaddr);
    check({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(eiv));
    check({tag, " instr_code"},  bus.instr_code, ecode);
    check({tag, " instr_pc"},    bus.instr_pc, epc);
  endtask

  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    logic        last_rv;
    int          issued;
    int          k;

    reset = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;

    //          rst rr rv rsp_d          rdv rdpc          ir | req_v addr          iv code           pc
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 1, 1, 32'hA000_0000, 0, 32'h0,       0,  1, 32'h4,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 1, 1, 32'hA000_0001, 0, 32'h0,       1,  1, 32'h8,        1, 32'hA000_0000, 32'h0));
    vt.push_back(mk(0, 1, 1, 32'hA000_0002, 0, 32'h0,       1,  1, 32'hC,        1, 32'hA000_0001, 32'h4));
    vt.push_back(mk(0, 1, 1, 32'hA000_0003, 0, 32'h0,       0,  1, 32'h10,       1, 32'hA000_0002, 32'h8));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h14,       1, 32'hA000_0002, 32'h8));
    vt.push_back(mk(0, 1, 1, 32'hA000_0004, 1, 32'h103,     1,  0, 32'h14,       1, 32'hA000_0002, 32'h8));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h100,      0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 1, 32'hB000_0000, 0, 32'h0,       0,  1, 32'h104,      0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h104,      1, 32'hB000_0000, 32'h100));
    vt.push_back(mk(0, 1, 0, 32'h0,        1, 32'hFFFF_FFFE, 1, 0, 32'h104,      0, 32'h0,        32'h0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0));
`ifdef FETCH_QUEUE_BYPASS_EN
    vt.push_back(mk(0, 1, 1, 32'hC000_0000, 0, 32'h0,       1,  1, 32'h0,        1, 32'hC000_0000, 32'hFFFF_FFFC));
    vt.push_back(mk(0, 0, 1, 32'hC000_0001, 0, 32'h0,       1,  1, 32'h4,        1, 32'hC000_0001, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h4,        0, 32'h0,        32'h0));
`else
    vt.push_back(mk(0, 1, 1, 32'hC000_0000, 0, 32'h0,       1,  1, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 1, 32'hC000_0001, 0, 32'h0,       1,  1, 32'h4,        1, 32'hC000_0000, 32'hFFFF_FFFC));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h4,        1, 32'hC000_0001, 32'h0));
`endif
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h4,        0, 32'h0,        32'h0));
    vt.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h8,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        32'h0));

    // One reset edge first so registered state is defined when row 0 is sampled.
    apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].req_rdy, vt[i].rsp_v, vt[i].rsp_d, vt[i].redir, vt[i].redir_pc,
            vt[i].in_rdy);
      check_outs($sformatf("vec%0d", i), vt[i].e_req_v, vt[i].e_addr, vt[i].e_iv,
                 vt[i].e_code, vt[i].e_pc);
    end

    // Redirect with three requests in flight: all three returning words must vanish.
    apply(1, 0, 0, 32'h0, 0, 32'h0, 1);
    apply(0, 1, 0, 32'h0, 0, 32'h0, 1);
    check("flush issue0 addr", bus.imem_req_addr, 32'h0);
    apply(0, 1, 0, 32'h0, 0, 32'h0, 1);
    apply(0, 1, 0, 32'h0, 0, 32'h0, 1);
    check("flush issue2 addr", bus.imem_req_addr, 32'h8);
    apply(0, 1, 0, 32'h0, 1, 32'h100, 1);
    check("flush redirect req_valid", 32'(bus.imem_req_valid), 32'h0);
    for (int s = 0; s < 3; s++) begin
      apply(0, 0, 1, 32'hDEAD_0000 + 32'(s), 0, 32'h0, 1);
      check($sformatf("flush stale%0d instr_valid", s), 32'(bus.instr_valid), 32'h0);
      check($sformatf("flush stale%0d req_addr", s), bus.imem_req_addr, 32'h100);
    end
    apply(0, 1, 0, 32'h0, 0, 32'h0, 1);
    check("flush new req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("flush quiet instr_valid", 32'(bus.instr_valid), 32'h0);
    apply(0, 0, 1, 32'hD000_0100, 0, 32'h0, 0);
    check("flush rsp cycle instr_valid", 32'(bus.instr_valid), 32'h0);
    apply(0, 0, 0, 32'h0, 0, 32'h0, 1);
    check_outs("flush first", 1'b1, 32'h104, 1'b1, 32'hD000_0100, 32'h100);
    apply(0, 0, 0, 32'h0, 0, 32'h0, 1);
    check("flush after pop instr_valid", 32'(bus.instr_valid), 32'h0);

    // Decode stalls for 10 cycles against a latency-1 memory: exactly DEPTH requests go out.
    apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
    pend = 1'b0;
    pend_addr = 32'h0;
    issued = 0;
    last_rv = 1'b1;
    for (int c = 0; c < 10; c++) begin
      apply(0, 1, pend, mem_word(pend_addr), 0, 32'h0, 0);
      last_rv = bus.imem_req_valid;
      if (bus.imem_req_valid) issued++;
      pend = bus.imem_req_valid;
      if (bus.imem_req_valid) pend_addr = bus.imem_req_addr;
    end
    check("stall requests issued", 32'(issued), 32'd4);
    check("stall req_valid low", 32'(last_rv), 32'h0);
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      apply(0, 1, pend, mem_word(pend_addr), 0, 32'h0, 1);
      if (bus.instr_valid) begin
        check($sformatf("drain%0d pc", k), bus.instr_pc, 32'(4 * k));
        check($sformatf("drain%0d code", k), bus.instr_code, mem_word(32'(4 * k)));
        k++;
      end
      pend = bus.imem_req_valid;
      if (bus.imem_req_valid) pend_addr = bus.imem_req_addr;
    end
    check("drain instructions received", 32'(k), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
